// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: shared definitions for the data-memory controller.
//   - dmem_state_e : 2-bit FSM state encodings (IDLE/ISSUE/WAIT/RESP)
//   - DMEM_LAT_CW  : latency counter width, covers READ_LATENCY 1..4
//   - RV_XLEN      : RISC-V word/address width reused for data and address
package dmem_ctrl_pkg;

   localparam int RV_XLEN     = 32;
   localparam int DMEM_LAT_CW = 2;

   typedef enum logic [1:0] {
      DMEM_ST_IDLE  = 2'd0,
      DMEM_ST_ISSUE = 2'd1,
      DMEM_ST_WAIT  = 2'd2,
      DMEM_ST_RESP  = 2'd3
   } dmem_state_e;

endpackage

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller between the LSU and a single-port
// synchronous SRAM. One transaction in flight at a time; every output is
// registered.
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   dmem_valid_i   request valid (held with addr/wdata/we until ready)
//   dmem_ready_o   one-cycle completion pulse
//   dmem_addr_i    byte address; bits [1:0] ignored
//   dmem_wdata_i   lane-aligned write data
//   dmem_we_i      byte strobes, 0 = read
//   dmem_rdata_o   read data, held until the next completed read
//   dmem_err_o     access fault, pulses with ready (range-check build only)
//   sram_*         SRAM strobe, byte enables, word address, write/read data
//
// Build option: define DMEM_CTRL_RANGE_CHECK_EN to fault requests outside
// [BASE_ADDR, BASE_ADDR + 4*2^SRAM_AW). Without it upper address bits are
// ignored and the SRAM aliases across the whole address space.
module dmem_ctrl
   import dmem_ctrl_pkg::*;
#(
   parameter int                    ADDR_WIDTH   = RV_XLEN,
   parameter int                    DATA_WIDTH   = RV_XLEN,
   parameter int                    SRAM_AW      = 12,
   parameter int                    READ_LATENCY = 1,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  dmem_valid_i,
   output logic                  dmem_ready_o,
   input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
   input  logic [DATA_WIDTH-1:0] dmem_wdata_i,
   input  logic [3:0]            dmem_we_i,
   output logic [DATA_WIDTH-1:0] dmem_rdata_o,
   output logic                  dmem_err_o,
   output logic                  sram_en_o,
   output logic [3:0]            sram_we_o,
   output logic [SRAM_AW-1:0]    sram_addr_o,
   output logic [DATA_WIDTH-1:0] sram_wdata_o,
   input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

   // First byte-address bit above the SRAM window.
   localparam int HI = SRAM_AW + 2;
   localparam logic [DMEM_LAT_CW-1:0] LAT_LOAD = DMEM_LAT_CW'(READ_LATENCY - 1);

   dmem_state_e            state;
   logic [DMEM_LAT_CW-1:0] cnt;
   logic                   is_write;

`ifdef DMEM_CTRL_RANGE_CHECK_EN
   logic fault_q;
   logic in_range;
   logic unused_bits;

   // BASE_ADDR is window-aligned, so the range test is an upper-bit match.
   assign in_range    = (dmem_addr_i[ADDR_WIDTH-1:HI] == BASE_ADDR[ADDR_WIDTH-1:HI]);
   assign unused_bits = ^dmem_addr_i[1:0];
`else
   logic unused_bits;

   assign dmem_err_o  = 1'b0;
   assign unused_bits = ^{dmem_addr_i[1:0], dmem_addr_i[ADDR_WIDTH-1:HI], BASE_ADDR};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= DMEM_ST_IDLE;
         cnt          <= '0;
         is_write     <= 1'b0;
         dmem_ready_o <= 1'b0;
         dmem_rdata_o <= '0;
         sram_en_o    <= 1'b0;
         sram_we_o    <= '0;
         sram_addr_o  <= '0;
         sram_wdata_o <= '0;
`ifdef DMEM_CTRL_RANGE_CHECK_EN
         fault_q      <= 1'b0;
         dmem_err_o   <= 1'b0;
`endif
      end else begin
         // Pulse outputs default low; set only on the edge entering their cycle.
         dmem_ready_o <= 1'b0;
         sram_en_o    <= 1'b0;
         sram_we_o    <= '0;
`ifdef DMEM_CTRL_RANGE_CHECK_EN
         dmem_err_o   <= 1'b0;
`endif
         unique case (state)
            DMEM_ST_IDLE: begin
               if (dmem_valid_i) begin
                  sram_addr_o  <= dmem_addr_i[HI-1:2];
                  sram_wdata_o <= dmem_wdata_i;
                  is_write     <= |dmem_we_i;
                  state        <= DMEM_ST_ISSUE;
`ifdef DMEM_CTRL_RANGE_CHECK_EN
                  // A fault still spends one slot in ISSUE (strobe suppressed)
                  // so its latency matches a write.
                  fault_q      <= ~in_range;
                  sram_en_o    <= in_range;
                  sram_we_o    <= in_range ? dmem_we_i : 4'b0000;
`else
                  sram_en_o    <= 1'b1;
                  sram_we_o    <= dmem_we_i;
`endif
               end
            end

            DMEM_ST_ISSUE: begin
`ifdef DMEM_CTRL_RANGE_CHECK_EN
               if (fault_q) begin
                  dmem_ready_o <= 1'b1;
                  dmem_err_o   <= 1'b1;
                  dmem_rdata_o <= '0;
                  state        <= DMEM_ST_RESP;
               end else
`endif
               if (is_write) begin
                  dmem_ready_o <= 1'b1;
                  state        <= DMEM_ST_RESP;
               end else begin
                  cnt   <= LAT_LOAD;
                  state <= DMEM_ST_WAIT;
               end
            end

            DMEM_ST_WAIT: begin
               // cnt==0 is the cycle sram_rdata_i carries the word.
               if (cnt == '0) begin
                  dmem_rdata_o <= sram_rdata_i;
                  dmem_ready_o <= 1'b1;
                  state        <= DMEM_ST_RESP;
               end else begin
                  cnt <= cnt - DMEM_LAT_CW'(1);
               end
            end

            DMEM_ST_RESP: begin
               // A valid seen here is the next request; IDLE captures it.
               state <= DMEM_ST_IDLE;
            end

            default: state <= DMEM_ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed scoreboard bench for dmem_ctrl (READ_LATENCY=3).
// The stimulus pushes expected SRAM strobes and ready responses into queues;
// a negedge monitor pops and compares whenever the DUT strobes or responds.
module tb_dmem_ctrl;

   localparam int RL     = 3;
   localparam int WR_LAT = 2;
   localparam int RD_LAT = 5;   // RL + 2

   logic        clk = 1'b0;
   logic        rst;
   logic        dmem_valid_i;
   logic        dmem_ready_o;
   logic [31:0] dmem_addr_i;
   logic [31:0] dmem_wdata_i;
   logic [3:0]  dmem_we_i;
   logic [31:0] dmem_rdata_o;
   logic        dmem_err_o;
   logic        sram_en_o;
   logic [3:0]  sram_we_o;
   logic [11:0] sram_addr_o;
   logic [31:0] sram_wdata_o;
   logic [31:0] sram_rdata_i;

   dmem_ctrl #(
      .ADDR_WIDTH   (32),
      .DATA_WIDTH   (32),
      .SRAM_AW      (12),
      .READ_LATENCY (RL),
      .BASE_ADDR    (32'h0000_0000)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .dmem_valid_i (dmem_valid_i),
      .dmem_ready_o (dmem_ready_o),
      .dmem_addr_i  (dmem_addr_i),
      .dmem_wdata_i (dmem_wdata_i),
      .dmem_we_i    (dmem_we_i),
      .dmem_rdata_o (dmem_rdata_o),
      .dmem_err_o   (dmem_err_o),
      .sram_en_o    (sram_en_o),
      .sram_we_o    (sram_we_o),
      .sram_addr_o  (sram_addr_o),
      .sram_wdata_o (sram_wdata_o),
      .sram_rdata_i (sram_rdata_i)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // SRAM model: byte-enable writes, read data RL cycles after the strobe.
   logic [31:0] mem [4096];
   logic [31:0] rd_pipe [RL];
   always @(posedge clk) begin
      if (sram_en_o === 1'b1) begin
         for (int b = 0; b < 4; b++)
            if (sram_we_o[b]) mem[sram_addr_o][8*b +: 8] <= sram_wdata_o[8*b +: 8];
         rd_pipe[0] <= mem[sram_addr_o];
      end
      for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign sram_rdata_i = rd_pipe[RL-1];

   typedef struct {
      int          cyc;
      logic [11:0] addr;
      logic [3:0]  we;
      logic [31:0] wdata;
   } iss_t;

   typedef struct {
      int          cyc;
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   iss_t iss_q[$];
   rsp_t rsp_q[$];
   int   tests = 0;
   int   fails = 0;
   int   inflight = 0;

   // Monitor
   always @(negedge clk) begin
      iss_t ei;
      rsp_t er;
      if (rst === 1'b1) inflight = 0;
      if (sram_en_o === 1'b1) begin
         tests++;
         if (inflight != 0) begin
            fails++;
            $display("FAIL inflight: cyc=%0d outstanding=%0d, required 0", cyc, inflight);
         end
         inflight++;
         tests++;
         if (iss_q.size() == 0) begin
            fails++;
            $display("FAIL sram_strobe: unexpected strobe cyc=%0d addr=%h", cyc, sram_addr_o);
         end else begin
            ei = iss_q.pop_front();
            if (cyc != ei.cyc || sram_addr_o !== ei.addr || sram_we_o !== ei.we ||
                sram_wdata_o !== ei.wdata) begin
               fails++;
               $display("FAIL sram_issue: got cyc=%0d addr=%h we=%b wdata=%h, required cyc=%0d addr=%h we=%b wdata=%h",
                        cyc, sram_addr_o, sram_we_o, sram_wdata_o, ei.cyc, ei.addr, ei.we, ei.wdata);
            end
         end
      end
      if (dmem_ready_o === 1'b1) begin
         if (inflight > 0) inflight--;
         tests++;
         if (rsp_q.size() == 0) begin
            fails++;
            $display("FAIL ready: unexpected ready cyc=%0d", cyc);
         end else begin
            er = rsp_q.pop_front();
            if (cyc != er.cyc || dmem_rdata_o !== er.rdata || dmem_err_o !== er.err) begin
               fails++;
               $display("FAIL response: got cyc=%0d rdata=%h err=%b, required cyc=%0d rdata=%h err=%b",
                        cyc, dmem_rdata_o, dmem_err_o, er.cyc, er.rdata, er.err);
            end
         end
      end
   end

   task automatic wait_ready();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (dmem_ready_o === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         tests++;
         fails++;
         $display("FAIL ready_timeout: no ready within 20 cycles at cyc=%0d", cyc);
      end
      @(posedge clk);
      #1;
   endtask

   // Drives a request (valid left high) and pushes its expectations.
   task automatic do_req(input logic [31:0] addr, input logic [3:0] we,
                         input logic [31:0] wdata, input bit issue,
                         input logic [11:0] waddr, input int lat,
                         input logic [31:0] exp_rd, input logic exp_err);
      int v;
      dmem_addr_i  = addr;
      dmem_we_i    = we;
      dmem_wdata_i = wdata;
      dmem_valid_i = 1'b1;
      v = cyc;
      if (issue) iss_q.push_back('{v + 1, waddr, we, wdata});
      rsp_q.push_back('{v + lat, exp_rd, exp_err});
      wait_ready();
   endtask

   task automatic idle(input int n);
      dmem_valid_i = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check32(input string name, input logic [31:0] got, input logic [31:0] req);
      tests++;
      if (got !== req) begin
         fails++;
         $display("FAIL %s: got %h, required %h", name, got, req);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held 3 cycles with a request already valid.
      rst          = 1'b1;
      dmem_valid_i = 1'b1;
      dmem_addr_i  = 32'h0000_0000;
      dmem_we_i    = 4'b1111;
      dmem_wdata_i = 32'h1234_5678;
      repeat (3) begin
         @(posedge clk);
         #1;
         check32("rst_sram_en", {31'd0, sram_en_o}, 32'd0);
         check32("rst_ready", {31'd0, dmem_ready_o}, 32'd0);
         check32("rst_rdata", dmem_rdata_o, 32'd0);
      end
      rst = 1'b0;
      // The held request is captured on the first edge with rst low.
      do_req(32'h0000_0000, 4'b1111, 32'h1234_5678, 1'b1, 12'h000, WR_LAT, 32'h0, 1'b0);
      idle(2);

      // Word store to word 0x041, then word load with READ_LATENCY=3.
      do_req(32'h0000_0104, 4'b1111, 32'hDEAD_BEEF, 1'b1, 12'h041, WR_LAT, 32'h0, 1'b0);
      idle(1);
      do_req(32'h0000_0104, 4'b0000, 32'h0, 1'b1, 12'h041, RD_LAT, 32'hDEAD_BEEF, 1'b0);
      idle(3);
      check32("rdata_persist", dmem_rdata_o, 32'hDEAD_BEEF);

      // Byte store to lane 1; addr[1:0] ignored.
      do_req(32'h0000_0105, 4'b0010, 32'h0000_AB00, 1'b1, 12'h041, WR_LAT, 32'hDEAD_BEEF, 1'b0);
      idle(1);
      check32("rdata_after_write", dmem_rdata_o, 32'hDEAD_BEEF);

      // Back-to-back with valid held: store, load same word, load merged word.
      do_req(32'h0000_0200, 4'b1111, 32'hCAFE_F00D, 1'b1, 12'h080, WR_LAT, 32'hDEAD_BEEF, 1'b0);
      do_req(32'h0000_0200, 4'b0000, 32'h0, 1'b1, 12'h080, RD_LAT, 32'hCAFE_F00D, 1'b0);
      do_req(32'h0000_0104, 4'b0000, 32'h0, 1'b1, 12'h041, RD_LAT, 32'hDEAD_ABEF, 1'b0);
      idle(2);

      // Reset during WAIT: strobe expected, no ready.
      begin
         int v;
         dmem_addr_i  = 32'h0000_0200;
         dmem_we_i    = 4'b0000;
         dmem_wdata_i = 32'h0;
         dmem_valid_i = 1'b1;
         v = cyc;
         iss_q.push_back('{v + 1, 12'h080, 4'b0000, 32'h0});
         @(posedge clk); #1;   // ISSUE
         @(posedge clk); #1;   // WAIT
         rst          = 1'b1;
         dmem_valid_i = 1'b0;
         @(posedge clk); #1;
         rst = 1'b0;
         check32("rst_mid_rdata", dmem_rdata_o, 32'd0);
         idle(6);
      end
      do_req(32'h0000_0104, 4'b0000, 32'h0, 1'b1, 12'h041, RD_LAT, 32'hDEAD_ABEF, 1'b0);
      idle(2);

      // Read beyond the 16 KiB window.
`ifdef DMEM_CTRL_RANGE_CHECK_EN
      do_req(32'h0000_4000, 4'b0000, 32'h0, 1'b0, 12'h000, WR_LAT, 32'h0, 1'b1);
`else
      do_req(32'h0000_4000, 4'b0000, 32'h0, 1'b1, 12'h000, RD_LAT, 32'h1234_5678, 1'b0);
`endif
      idle(5);

      tests++;
      if (iss_q.size() != 0 || rsp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d strobes and %0d responses outstanding, required 0",
                  iss_q.size(), rsp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
